// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte/strobe/status outputs toward the consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (output rx, input data, valid, frame_err, parity_err, busy);
  modport slave  (input rx, output data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8-bit LSB-first UART receiver, 16x oversampled from clki, one stop bit; strobes are one cycle wide.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_err; default build is 8N1.
module uart_rx #(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 1200
) (
  input  logic     clki,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int          OVS_DIV   = CLK_HZ / (BAUD * 16);
  localparam logic [15:0] TICK_LAST = 16'(OVS_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY  = 3'd5
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_rx_s;
  logic [15:0] r_tick_cnt;
  logic [3:0]  r_ovs;
  logic [2:0]  r_bitn;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;

  logic        w_tick;
  logic        w_bit_end;
  logic        w_busy;
  logic        w_start_det;
  logic        w_mid_start;
  logic        w_take_bit;
  logic        w_stop_smp;
  logic        w_set_valid;
  logic        w_set_ferr;
  logic        w_par_ok;

  // Both synchronizer flops idle at the line's mark level so reset never looks like a start bit.
  always_ff @(posedge clki) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clki) begin
    if (rst) begin
      r_tick_cnt <= 16'd0;
    end else if (w_start_det || w_tick) begin
      r_tick_cnt <= 16'd0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_next = S_START;
      end
      S_START: begin
        if (w_tick && (r_ovs == 4'd7)) w_next = r_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bitn == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) w_next = r_rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH);
    w_start_det = (r_state == S_IDLE) && !r_rx_s;
    w_bit_end   = w_tick && (r_ovs == 4'd15);
    w_mid_start = (r_state == S_START) && w_tick && (r_ovs == 4'd7);
    w_take_bit  = (r_state == S_DATA) && w_bit_end;
    w_stop_smp  = (r_state == S_STOP) && w_bit_end;
    // A low stop bit wins over a parity mismatch.
    w_set_ferr  = w_stop_smp && !r_rx_s;
    w_set_valid = w_stop_smp && r_rx_s && w_par_ok;
  end

  // ovs restarts at mid start bit so every later sample lands 16 ticks apart, mid-bit.
  always_ff @(posedge clki) begin
    if (rst) begin
      r_ovs   <= 4'd0;
      r_bitn  <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (w_start_det || w_mid_start) begin
        r_ovs <= 4'd0;
      end else if (w_tick && w_busy) begin
        r_ovs <= r_ovs + 4'd1;
      end
      if (w_mid_start) begin
        r_bitn <= 3'd0;
      end else if (w_take_bit) begin
        r_bitn <= r_bitn + 3'd1;
      end
      if (w_take_bit) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= w_set_valid;
      r_frame_err <= w_set_ferr;
      if (w_set_valid) r_data <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  assign w_par_ok = !r_par_bad;

  always_ff @(posedge clki) begin
    if (rst) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_bit_end) r_par_bad <= (^r_shift) ^ r_rx_s;
      r_parity_err <= w_stop_smp && r_rx_s && r_par_bad;
    end
  end

  assign bus.parity_err = r_parity_err;
`else
  assign w_par_ok       = 1'b1;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx against a frame-level reference model.
module tb_uart_rx;
  localparam int CLK_HZ  = 24000000;
  localparam int BAUD    = 750000;
  localparam int DIV     = CLK_HZ / (BAUD * 16);
  localparam int BIT_CYC = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 168 * DIV + 3;
`else
  localparam int LAT = 152 * DIV + 3;
`endif

  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         t;
  } ev_t;

  logic clki = 1'b0;
  logic rst  = 1'b1;
  uart_rx_if bus();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clki = ~clki;

  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  // Observation side: every strobe becomes an event; pulse width and data stability are tallied.
  ev_t        obs_q[$];
  int         long_pulse  = 0;
  int         data_glitch = 0;
  int         busy_cycles = 0;
  logic       prev_v      = 1'b0;
  logic       prev_f      = 1'b0;
  logic       prev_rst    = 1'b1;
  logic [7:0] prev_d      = 8'h00;

  always @(negedge clki) begin
    if (bus.valid)      obs_q.push_back('{K_VALID, bus.data, cyc});
    if (bus.frame_err)  obs_q.push_back('{K_FERR,  bus.data, cyc});
    if (bus.parity_err) obs_q.push_back('{K_PERR,  bus.data, cyc});
    if ((bus.valid && prev_v) || (bus.frame_err && prev_f)) long_pulse++;
    if (!bus.valid && !prev_rst && (bus.data !== prev_d)) data_glitch++;
    if (bus.busy) busy_cycles++;
    prev_v   = bus.valid;
    prev_f   = bus.frame_err;
    prev_rst = rst;
    prev_d   = bus.data;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  ev_t        exp_q[$];
  int         rd_idx = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: frame outcome from line-level rules only.
  task automatic expect_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    if (!stop_v) begin
      exp_q.push_back('{K_FERR, last_good, 0});
    end else begin
`ifdef UART_RX_PARITY_EN
      if (par_flip) exp_q.push_back('{K_PERR, last_good, 0});
      else begin
        exp_q.push_back('{K_VALID, b, 0});
        last_good = b;
      end
`else
      if (par_flip) begin end
      exp_q.push_back('{K_VALID, b, 0});
      last_good = b;
`endif
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (BIT_CYC) @(posedge clki);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_v);
    bus.rx = 1'b1;
    expect_frame(b, stop_v, par_flip);
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * BIT_CYC) @(posedge clki);
    #1;
  endtask

  task automatic check_events(input string tag);
    int n_obs;
    n_obs = obs_q.size() - rd_idx;
    chk({tag, "_count"}, n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_idx + i < obs_q.size()) begin
        chk({tag, "_kind"}, obs_q[rd_idx + i].kind, exp_q[i].kind);
        chk({tag, "_data"}, {24'd0, obs_q[rd_idx + i].d}, {24'd0, exp_q[i].d});
      end
    end
    exp_q.delete();
    rd_idx = obs_q.size();
  endtask

  initial begin
    int         t0;
    int         b0;
    int         lat;
    logic [7:0] rb;
    logic       rs;
    logic       rp;

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(posedge clki);
    #1 rst = 1'b0;
    @(negedge clki);
    chk("rst_data",  {24'd0, bus.data}, 32'h0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
    chk("rst_perr",  {31'd0, bus.parity_err}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    @(posedge clki);
    #1;
    idle_bits(1);

    // Single A5 frame with start-edge-to-valid latency
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(2);
    if (obs_q.size() > rd_idx) begin
      lat = obs_q[rd_idx].t - t0;
      n_cmp++;
      assert ((lat >= LAT - 1) && (lat <= LAT + 1)) else begin
        n_bad++;
        $error("FAIL lat_a5: observed %0d expected %0d+-1", lat, LAT);
      end
    end
    check_events("a5");

    // Back-to-back frames, one stop bit each
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(2);
    check_events("b2b");

    // Short glitch: busy must pulse, nothing emitted
    b0 = busy_cycles;
    bus.rx = 1'b0;
    repeat (4) @(posedge clki);
    #1 bus.rx = 1'b1;
    idle_bits(2);
    chk("glitch_busy_seen", {31'd0, busy_cycles > b0}, 32'd1);
    chk("glitch_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("glitch_data", {24'd0, bus.data}, {24'd0, last_good});
    check_events("glitch");

    // Low stop bit followed by a long break, then a good frame
    send_frame(8'h55, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (40 * BIT_CYC) @(posedge clki);
    #1;
    idle_bits(2);
    check_events("break");
    send_frame(8'h12, 1'b1, 1'b0);
    idle_bits(2);
    check_events("after_break");

    // Reset pulse during bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    bus.rx = 1'b0;
    repeat (BIT_CYC / 2) @(posedge clki);
    #1;
    bus.rx = 1'b1;
    rst    = 1'b1;
    @(posedge clki);
    #1 rst = 1'b0;
    @(negedge clki);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_data", {24'd0, bus.data}, 32'h0);
    last_good = 8'h00;
    @(posedge clki);
    #1;
    idle_bits(2);
    check_events("midrst");
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);
    check_events("after_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check_events("parity");
    chk("parity_data_kept", {24'd0, bus.data}, 32'h07);
`endif

    // Randomized frames: random bytes, occasional bad stop (and bad parity when compiled in)
    for (int n = 0; n < 14; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      rp = ($urandom_range(0, 4) == 0);
      send_frame(rb, rs, rp);
      if (!rs) idle_bits(1 + $urandom_range(0, 1));
      else if ($urandom_range(0, 2) == 0) idle_bits($urandom_range(1, 2));
    end
    idle_bits(3);
    check_events("rand");
    chk("final_data", {24'd0, bus.data}, {24'd0, last_good});

    chk("strobe_width", long_pulse, 32'd0);
    chk("data_stable", data_glitch, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide asynchronous serial receiver, 8 data bits, LSB first, one stop bit. It is the receive end of the design's UART link and runs directly from the 24 MHz board clock. It has an internal 16x oversampling tick generator, so it needs no separately divided bit clock. Received bytes are presented as a one-cycle `valid` strobe, or a one-cycle error strobe, to the downstream consumer.

## Interface
- `CLK_HZ`, 24000000: frequency of `clki` in Hz.
- `BAUD`, 1200: line bit rate. `OVS_DIV = CLK_HZ / (BAUD*16)`, integer-truncated; legal range 2..65535.
- `clki` input, 1 bit: the only clock. All logic is on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `rx` input, 1 bit: asynchronous serial line; idles high.
- `data` output, 8 bits: last good byte. Changes only when `valid` pulses.
- `valid` output, 1 bit: one-cycle pulse when a good frame has been received.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `parity_err` output, 1 bit: one-cycle pulse when the parity bit mismatches. Constant 0 unless parity is compiled in.
- `busy` output, 1 bit: high from start detection until the frame is finished.

## Operation
- `rx` passes through a 2-flop synchronizer to `rx_s`. Both flops reset to 1.
- Tick generator: a 16-bit counter counts 0..`OVS_DIV`-1. It emits `tick` for one cycle on the terminal count, then wraps to 0. The counter is forced to 0 on start detection, so ticks are phase-aligned to the start edge.
- A 4-bit `ovs` counter counts ticks within a bit. A 3-bit `bitn` counter indexes data bits.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
  - IDLE: `rx_s`==0 → START. Clear `ovs` and the tick counter; `busy`=1.
  - START: on the 8th tick (mid start bit), if `rx_s`==0 → DATA with `ovs`=0 and `bitn`=0. If `rx_s`==1, treat it as a glitch → IDLE with `busy`=0.
  - DATA: on every 16th tick, shift `rx_s` into the shift register MSB (LSB-first line order) and increment `bitn`. After bit 7 → PARITY if enabled, else STOP.
  - PARITY: on the 16th tick, latch `par_bad` = XOR(shift reg, `rx_s`) under even parity. → STOP.
  - STOP: on the 16th tick, sample `rx_s`:
    - `rx_s`==1 and no parity error: `valid`=1, `data`=shift reg → IDLE.
    - `rx_s`==1 and `par_bad`: `parity_err`=1, `data` unchanged → IDLE.
    - `rx_s`==0: `frame_err`=1 (takes priority over parity), `data` unchanged → WAIT_HIGH.
  - WAIT_HIGH: stays until `rx_s`==1 → IDLE. A break or stuck-low line therefore yields exactly one `frame_err` and no byte stream.
- `busy`=0 in IDLE and WAIT_HIGH, 1 otherwise.
- Reset mid-frame: next cycle is IDLE. Outputs go to reset values and the partial byte is discarded; no strobe is emitted.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0. Synchronizer flops = 1. FSM = IDLE. Counters = 0.
- `rx` to `rx_s` latency: 2 cycles. Start detection is registered on the 3rd `clki` edge after `rx` falls.
- Sample points, counted in ticks after start detection:
  - start: 8.
  - data bit k: 24+16k.
  - parity (if enabled): 152.
  - stop: 152 without parity, 168 with parity.
- Strobes assert in the cycle after the stop-sample tick and last exactly one cycle. `data` updates in that same cycle.
- 8N1 total: the `valid` rising edge is 152·`OVS_DIV` + 3 cycles after the `rx` falling edge (±1 cycle for synchronizer phase).
- The receiver is back in IDLE on the same cycle the strobe asserts. The next start bit is accepted from the following cycle, so back-to-back frames with one stop bit are received.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state is present. The frame is 8E1 and `parity_err` is live.
- Not defined: no PARITY state, the frame is 8N1, and `parity_err` is tied 0. Port list is identical in both builds.

## Test plan
- BAUD=750000 (`OVS_DIV`=2), send 8'hA5 as 8N1 → one `valid` pulse with `data`=8'hA5, 307±1 cycles after the start edge. `frame_err`=0.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with one stop bit each → three `valid` pulses, `data` in that order. No errors and no missed bytes.
- Pull `rx` low for 4 cycles (shorter than half a bit) → `busy` pulses, then returns to IDLE. No strobes; `data` unchanged.
- Send 8'h55 with the stop bit low, then hold `rx` low for 40 bit times → exactly one `frame_err` and no `valid`. A subsequent good 8'h12 gives `valid` with `data`=8'h12.
- Assert `rst` for 1 cycle during bit 4 of a frame → `busy`=0 next cycle and no strobe. The next full frame 8'h81 is received correctly.
- With `UART_RX_PARITY_EN`: send 8'h07 with parity bit 1 (correct) → `valid`. Resend with parity bit 0 → `parity_err` pulse, no `valid`, `data` stays 8'h07.
